uart_bus_loader: RTL and testbench

//  Byte-stream-driven initiator on the native picorv32 memory bus (valid/ready/addr/wdata/wstrb/rdata).

---
 rtl/uart_bus_loader.sv | 184 ++++++++++++++++++
 tb/tb_uart_bus_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_loader.sv
// Byte-stream command decoder that issues single-word reads/writes on the picorv32 native bus.
// Optional 'N' (write to last address + 4) command is enabled by defining LOADER_AUTOINC_EN.
module uart_bus_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
`ifdef LOADER_AUTOINC_EN
    localparam logic [7:0] CMD_N = 8'h4E;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        REPLY
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          take;
    logic          bus_done;
    logic          bus_timeout;
    logic [1:0]    idx;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   addr_n;
    logic [31:0]   wdata;
    logic [31:0]   reply_buf;
    logic [1:0]    reply_last;
    logic [TW-1:0] tcnt;
`ifdef LOADER_AUTOINC_EN
    logic [31:0]   last_addr;
`endif

    assign m_addr   = addr & 32'hFFFF_FFFC;
    assign m_wdata  = wdata;
    assign out_data = reply_buf[7:0];
    assign busy     = (state != IDLE);

    always_comb begin
        state_n     = state;
        in_ready    = !reset && (state == IDLE || state == ADDR || state == DATA);
        take        = in_valid && in_ready;
        bus_done    = m_valid && m_ready;
        bus_timeout = !bus_done && (tcnt == T_LAST);
        addr_n      = addr;
        if (state == ADDR && take)
            addr_n = {in_data, addr[31:8]};

        case (state)
            IDLE: begin
                if (take) begin
                    if (in_data == CMD_W || in_data == CMD_R)
                        state_n = ADDR;
`ifdef LOADER_AUTOINC_EN
                    else if (in_data == CMD_N)
                        state_n = DATA;
`endif
                    else
                        state_n = REPLY;
                end
            end
            ADDR:    if (take && idx == 2'd3) state_n = wr ? DATA : BUS;
            DATA:    if (take && idx == 2'd3) state_n = BUS;
            BUS:     if (bus_done || bus_timeout) state_n = REPLY;
            REPLY:   if (out_valid && out_ready && idx == reply_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            wr         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            reply_buf  <= '0;
            reply_last <= '0;
            tcnt       <= '0;
            m_valid    <= 1'b0;
            m_wstrb    <= 4'h0;
            out_valid  <= 1'b0;
`ifdef LOADER_AUTOINC_EN
            last_addr  <= '0;
`endif
        end else begin
            // The byte index restarts on every state entry so each field starts at byte 0.
            if (state_n != state)
                idx <= '0;
            else if ((take && (state == ADDR || state == DATA)) ||
                     (state == REPLY && out_valid && out_ready))
                idx <= idx + 2'd1;

            addr <= addr_n;

            case (state)
                IDLE: begin
                    if (take) begin
                        wr <= (in_data != CMD_R);
`ifdef LOADER_AUTOINC_EN
                        if (in_data == CMD_N)
                            addr <= last_addr + 32'd4;
`endif
                        if (state_n == REPLY) begin
                            reply_buf  <= {24'h0, NAK_BYTE};
                            reply_last <= 2'd0;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (take)
                        wdata <= {in_data, wdata[31:8]};
                end
                BUS: begin
                    if (bus_done) begin
                        m_valid    <= 1'b0;
                        out_valid  <= 1'b1;
                        reply_buf  <= wr ? {24'h0, ACK_BYTE} : m_rdata;
                        reply_last <= wr ? 2'd0 : 2'd3;
                    end else if (bus_timeout) begin
                        m_valid    <= 1'b0;
                        out_valid  <= 1'b1;
                        reply_buf  <= {24'h0, NAK_BYTE};
                        reply_last <= 2'd0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                REPLY: begin
                    if (out_valid && out_ready) begin
                        if (idx == reply_last)
                            out_valid <= 1'b0;
                        else
                            reply_buf <= {8'h0, reply_buf[31:8]};
                    end
                end
                default: ;
            endcase

            // Request is launched on BUS entry and held unchanged until completion or timeout.
            if (state_n == BUS && state != BUS) begin
                m_valid <= 1'b1;
                m_wstrb <= wr ? 4'hF : 4'h0;
                tcnt    <= '0;
`ifdef LOADER_AUTOINC_EN
                last_addr <= addr_n & 32'hFFFF_FFFC;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_loader.sv
// Directed self-checking bench for uart_bus_loader (short timeout for fast runs).
module tb_uart_bus_loader;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        busy;
    logic        resp_en;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Responder: combinational ready when enabled.
    assign m_ready = m_valid && resp_en;

    uart_bus_loader #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; presents one byte for one edge.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        chk("in_ready", {31'h0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [31:0] f1, input bit has_f1,
                            input logic [31:0] f2, input bit has_f2);
        logic [31:0] a;
        logic [31:0] d;
        a = f1;
        d = f2;
        send_byte(c);
        if (has_f1) for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (has_f2) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic expect_reply(input string tag, input logic [31:0] exp, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (!out_valid && w < 50) begin
                step();
                w++;
            end
            chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
            chk({tag, "_byte"}, {24'h0, out_data}, {24'h0, exp[8*i +: 8]});
            step();
        end
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_done_busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int cnt;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        resp_en   = 1'b0;
        m_rdata   = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_m_wstrb", {28'h0, m_wstrb}, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        reset = 1'b0;
        step();
        chk("idle_in_ready", {31'h0, in_ready}, 32'h1);

        // Write, ready one cycle late
        send_cmd(8'h57, 32'h0000_2000, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("wr_m_valid", {31'h0, m_valid}, 32'h1);
        chk("wr_m_addr", m_addr, 32'h0000_2000);
        chk("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("wr_m_wstrb", {28'h0, m_wstrb}, 32'hF);
        chk("wr_in_ready_bus", {31'h0, in_ready}, 32'h0);
        step();
        chk("wr_m_valid_hold", {31'h0, m_valid}, 32'h1);
        chk("wr_m_addr_hold", m_addr, 32'h0000_2000);
        resp_en = 1'b1;
        step();
        resp_en = 1'b0;
        chk("wr_m_valid_drop", {31'h0, m_valid}, 32'h0);
        expect_reply("wr_ack", 32'h06, 1);

        // Read with immediate ready
        resp_en = 1'b1;
        m_rdata = 32'h1234_5678;
        send_cmd(8'h52, 32'h0000_2000, 1'b1, 32'h0, 1'b0);
        chk("rd_m_valid", {31'h0, m_valid}, 32'h1);
        chk("rd_m_wstrb", {28'h0, m_wstrb}, 32'h0);
        chk("rd_m_addr", m_addr, 32'h0000_2000);
        step();
        resp_en = 1'b0;
        m_rdata = 32'h0;
        chk("rd_m_valid_drop", {31'h0, m_valid}, 32'h0);
        expect_reply("rd_data", 32'h1234_5678, 4);

        // Read timeout
        send_cmd(8'h52, 32'h0000_0010, 1'b1, 32'h0, 1'b0);
        cnt = 0;
        while (m_valid && cnt < 100) begin
            cnt++;
            step();
        end
        chk("to_cycles", cnt, TO);
        chk("to_busy", {31'h0, busy}, 32'h1);
        expect_reply("to_nak", 32'h15, 1);

        // Unknown byte with stalled sink; input ignored while replying
        send_byte(8'hAA);
        in_valid = 1'b1;
        in_data  = 8'h57;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", {31'h0, out_valid}, 32'h1);
            chk("hold_data", {24'h0, out_data}, 32'h15);
            chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
            step();
        end
        in_valid = 1'b0;
        expect_reply("aa_nak", 32'h15, 1);

`ifdef LOADER_AUTOINC_EN
        // Autoincrement wraps past the top of the address space
        resp_en = 1'b1;
        send_cmd(8'h57, 32'hFFFF_FFFC, 1'b1, 32'h0000_0001, 1'b1);
        chk("ai_w_addr", m_addr, 32'hFFFF_FFFC);
        chk("ai_w_data", m_wdata, 32'h1);
        step();
        expect_reply("ai_w_ack", 32'h06, 1);
        send_cmd(8'h4E, 32'h0000_0002, 1'b1, 32'h0, 1'b0);
        chk("ai_n_addr", m_addr, 32'h0);
        chk("ai_n_data", m_wdata, 32'h2);
        chk("ai_n_wstrb", {28'h0, m_wstrb}, 32'hF);
        step();
        resp_en = 1'b0;
        expect_reply("ai_n_ack", 32'h06, 1);
`else
        send_byte(8'h4E);
        expect_reply("n_nak", 32'h15, 1);
`endif

        // Reset while the request is outstanding
        send_cmd(8'h52, 32'h0000_0044, 1'b1, 32'h0, 1'b0);
        chk("mid_m_valid", {31'h0, m_valid}, 32'h1);
        reset = 1'b1;
        step();
        chk("mid_rst_m_valid", {31'h0, m_valid}, 32'h0);
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        reset = 1'b0;
        step();
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_no_reply", {31'h0, out_valid}, 32'h0);

        // Read after reset; low address bits are forced to zero
        resp_en = 1'b1;
        m_rdata = 32'hA5A5_5A5A;
        send_cmd(8'h52, 32'h0000_0007, 1'b1, 32'h0, 1'b0);
        chk("post_m_addr", m_addr, 32'h0000_0004);
        step();
        resp_en = 1'b0;
        expect_reply("post_rd", 32'hA5A5_5A5A, 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
